// File: rtl/ahmes_flags_pkg.sv
// Shared types and constants for the processor status (flag) register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ahmes_flags_pkg;

    // Flag-word manipulation applied after the optional masked load.
    typedef enum logic [1:0] {
        NOP = 2'd0,
        SET = 2'd1,
        CLR = 2'd2,
        TOG = 2'd3
    } flag_op_t;

    // Bit positions for the default five-flag word {N,Z,C,B,V}.
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_B = 1;
    localparam int FLAG_V = 0;

    localparam int DEFAULT_NFLAGS = 5;

endpackage

// File: rtl/flag_stack.sv
// LIFO shadow stack for flag words with push, pop and in-place swap of the top entry.
// Latency: depth/contents update on the clock edge; top entry is read combinationally from storage.
// Backpressure: none; push while full and pop/swap while empty are dropped here (the caller flags errors).
`timescale 1ns/1ps
import ahmes_flags_pkg::*;

module flag_stack #(
    parameter int NFLAGS = DEFAULT_NFLAGS,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       swap_i,
    input  logic [NFLAGS-1:0]          wr_dat_i,
    output logic [NFLAGS-1:0]          top_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] mem_q [DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic [IW-1:0]     top_idx, wr_idx;
    logic              empty, full;
    logic              do_push, do_pop, do_swap, wr_en;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(DEPTH));
    assign top_idx = IW'(depth_q - DW'(1));

    // Qualify requests against occupancy so the counter can never wrap.
    always_comb begin
        do_push = push_i & ~full;
        do_pop  = pop_i  & ~empty;
        do_swap = swap_i & ~empty;
        wr_en   = do_push | do_swap;
        // A swap overwrites the current top; a push writes the next free slot.
        wr_idx  = do_swap ? top_idx : IW'(depth_q);
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + DW'(1);
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Occupancy counter; the only stack state that needs a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat_i;
        end
    end

    assign top_dat_o = empty ? '0 : mem_q[top_idx];
    assign depth_o   = depth_q;
    assign empty_o   = empty;
    assign full_o    = full;

endmodule

// File: rtl/flag_file.sv
// Status flag register: masked load, set/clear/toggle, and a shadow stack for save/restore.
// Latency: every effect appears on the outputs one cycle after inputs are sampled; outputs are registered.
// Backpressure: none; illegal push/pop requests are dropped and recorded in sticky error flags.
`timescale 1ns/1ps
import ahmes_flags_pkg::*;

module flag_file #(
    parameter int                NFLAGS    = DEFAULT_NFLAGS,
    parameter int                DEPTH     = 4,
    parameter logic [NFLAGS-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_en,
    input  logic [NFLAGS-1:0]          load_mask,
    input  logic [NFLAGS-1:0]          flags_in,
    input  flag_op_t                   op,
    input  logic [NFLAGS-1:0]          op_mask,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [NFLAGS-1:0]          flags_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_empty,
    output logic                       stack_full,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int DW = $clog2(DEPTH + 1);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [NFLAGS-1:0] top_dat;
    logic [DW-1:0]     stk_depth;
    logic              stk_empty, stk_full;

    logic              stk_push, stk_pop, stk_swap;
    logic              ovf_evt, unf_evt, take_top;
    logic [NFLAGS-1:0] f_load, f_op;

    flag_stack #(
        .NFLAGS (NFLAGS),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (stk_push),
        .pop_i     (stk_pop),
        .swap_i    (stk_swap),
        .wr_dat_i  (flags_q),
        .top_dat_o (top_dat),
        .depth_o   (stk_depth),
        .empty_o   (stk_empty),
        .full_o    (stk_full)
    );

    // Classify push/pop into stack actions and error events.
    always_comb begin
        // Push+pop on an empty stack degrades to a plain push plus an underflow.
        stk_push = push & ((~pop & ~stk_full) | (pop & stk_empty));
        stk_pop  = pop & ~push & ~stk_empty;
        stk_swap = push & pop & ~stk_empty;
        ovf_evt  = push & ~pop & stk_full;
        unf_evt  = pop & stk_empty;
        // A restore from the stack overrides load and op for the cycle.
        take_top = stk_pop | stk_swap;
    end

    // Normal flag update: masked load first, then the set/clear/toggle op.
    always_comb begin
        f_load = flags_q;
        if (load_en) begin
            f_load = (flags_q & ~load_mask) | (flags_in & load_mask);
        end
        f_op = f_load;
        case (op)
            NOP:     f_op = f_load;
            SET:     f_op = f_load | op_mask;
            CLR:     f_op = f_load & ~op_mask;
            TOG:     f_op = f_load ^ op_mask;
            default: f_op = f_load;
        endcase
        flags_d = take_top ? top_dat : f_op;
    end

    // Sticky errors: a new event in the same cycle beats err_clr.
    always_comb begin
        ovf_d = ovf_evt | (ovf_q & ~err_clr);
        unf_d = unf_evt | (unf_q & ~err_clr);
    end

    // Flag word and error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= RESET_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign flags_out     = flags_q;
    assign depth         = stk_depth;
    assign stack_empty   = stk_empty;
    assign stack_full    = stk_full;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_file.sv
`timescale 1ns/1ps
module tb_flag_file;
    import ahmes_flags_pkg::*;

    localparam int NF = 5;
    localparam int DP = 4;
    localparam int DW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          load_en;
    logic [NF-1:0] load_mask, flags_in, op_mask;
    flag_op_t      op;
    logic          push, pop, err_clr;
    logic [NF-1:0] flags_out;
    logic [DW-1:0] depth;
    logic          stack_empty, stack_full, overflow_err, underflow_err;

    flag_file #(.NFLAGS(NF), .DEPTH(DP), .RESET_VAL('0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en       (load_en),
        .load_mask     (load_mask),
        .flags_in      (flags_in),
        .op            (op),
        .op_mask       (op_mask),
        .push          (push),
        .pop           (pop),
        .err_clr       (err_clr),
        .flags_out     (flags_out),
        .depth         (depth),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    typedef struct {
        logic [NF-1:0] flags;
        int            dep;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: flag word, a queue used as the LIFO, sticky errors.
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stack[$];
    logic          m_ovf, m_unf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NF-1:0] normal(input logic [NF-1:0] f, input logic le,
                                             input logic [NF-1:0] lm, input logic [NF-1:0] fi,
                                             input flag_op_t o, input logic [NF-1:0] om);
        logic [NF-1:0] r;
        r = f;
        for (int b = 0; b < NF; b++)
            if (le && lm[b]) r[b] = fi[b];
        case (o)
            SET: r = r | om;
            CLR: r = r & ~om;
            TOG: r = r ^ om;
            default: ;
        endcase
        return r;
    endfunction

    task automatic model_step(input logic le, input logic [NF-1:0] lm, input logic [NF-1:0] fi,
                              input flag_op_t o, input logic [NF-1:0] om,
                              input logic pu, input logic po, input logic ec);
        logic [NF-1:0] nf;
        logic [NF-1:0] t;
        logic ov, un;
        nf = normal(m_flags, le, lm, fi, o, om);
        ov = 1'b0;
        un = 1'b0;
        if (pu && po) begin
            if (m_stack.size() > 0) begin
                t = m_stack.pop_back();
                m_stack.push_back(m_flags);
                nf = t;
            end else begin
                un = 1'b1;
                m_stack.push_back(m_flags);
            end
        end else if (pu) begin
            if (m_stack.size() < DP) m_stack.push_back(m_flags);
            else ov = 1'b1;
        end else if (po) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else un = 1'b1;
        end
        m_flags = nf;
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ov) m_ovf = 1'b1;
        if (un) m_unf = 1'b1;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.flags = m_flags;
        e.dep   = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    // One clock of stimulus; expectation is queued once the edge has passed.
    task automatic cycle(input logic le, input logic [NF-1:0] lm, input logic [NF-1:0] fi,
                         input flag_op_t o, input logic [NF-1:0] om,
                         input logic pu, input logic po, input logic ec);
        load_en = le; load_mask = lm; flags_in = fi;
        op = o; op_mask = om; push = pu; pop = po; err_clr = ec;
        model_step(le, lm, fi, o, om, pu, po, ec);
        @(posedge clk);
        #1;
        exp_q.push_back(snapshot());
    endtask

    task automatic idle_inputs();
        load_en = 0; load_mask = '0; flags_in = '0;
        op = NOP; op_mask = '0; push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, 32'(flags_out), 32'h0);
        chk({tag, "_depth"}, 32'(depth), 32'h0);
        chk({tag, "_empty"}, 32'(stack_empty), 32'h1);
        chk({tag, "_full"}, 32'(stack_full), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow_err), 32'h0);
        chk({tag, "_unf"}, 32'(underflow_err), 32'h0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic reset_mid_cycle();
        @(negedge clk);
        #1;
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        m_flags = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compares every queued expectation against the outputs.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("flags_out", 32'(flags_out), 32'(mon_e.flags));
            chk("depth", 32'(depth), 32'(mon_e.dep));
            chk("stack_empty", 32'(stack_empty), 32'(mon_e.dep == 0));
            chk("stack_full", 32'(stack_full), 32'(mon_e.dep == DP));
            chk("overflow_err", 32'(overflow_err), 32'(mon_e.ovf));
            chk("underflow_err", 32'(underflow_err), 32'(mon_e.unf));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        m_flags = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst_init");
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Masked load, then load combined with a toggle.
        cycle(1, 5'b10100, 5'b11111, NOP, 5'b00000, 0, 0, 0);
        cycle(0, 5'b00000, 5'b00000, CLR, 5'b11111, 0, 0, 0);
        cycle(1, 5'b10100, 5'b11111, TOG, 5'b00001, 0, 0, 0);

        // Push/pop round trip; load and op in the pop cycle are ignored.
        cycle(1, 5'b11111, 5'b01001, NOP, 5'b00000, 0, 0, 0);
        cycle(0, 5'b00000, 5'b00000, NOP, 5'b00000, 1, 0, 0);
        cycle(1, 5'b11111, 5'b11111, NOP, 5'b00000, 0, 0, 0);
        cycle(1, 5'b11111, 5'b00000, SET, 5'b11111, 0, 1, 0);

        // Fill to overflow, err_clr losing to a new event, then clearing.
        for (int i = 0; i < 5; i++) cycle(0, '0, '0, TOG, 5'(i + 1), 1, 0, 0);
        cycle(0, '0, '0, NOP, '0, 1, 0, 1);
        cycle(0, '0, '0, NOP, '0, 0, 0, 1);
        // Swap while full, then drain to check LIFO order.
        cycle(0, '0, '0, NOP, '0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, '0, NOP, '0, 0, 1, 0);

        // Underflow: pop while empty lets the load through.
        cycle(1, 5'b11111, 5'b00011, NOP, '0, 0, 1, 0);
        cycle(0, '0, '0, NOP, '0, 0, 0, 1);

        // Swap with one entry.
        cycle(1, 5'b11111, 5'b10000, NOP, '0, 0, 0, 0);
        cycle(0, '0, '0, NOP, '0, 1, 0, 0);
        cycle(1, 5'b11111, 5'b00001, NOP, '0, 0, 0, 0);
        cycle(1, 5'b11111, 5'b01110, TOG, 5'b11111, 1, 1, 0);
        cycle(0, '0, '0, NOP, '0, 0, 1, 0);

        // Push+pop on empty: underflow plus a plain push.
        cycle(1, 5'b11111, 5'b00110, NOP, '0, 1, 1, 0);
        cycle(0, '0, '0, NOP, '0, 0, 1, 0);
        cycle(0, '0, '0, NOP, '0, 0, 0, 1);

        // Reset between edges with flags=10110 and depth=2.
        cycle(0, '0, '0, NOP, '0, 1, 0, 0);
        cycle(0, '0, '0, NOP, '0, 1, 0, 0);
        cycle(1, 5'b11111, 5'b10110, NOP, '0, 0, 0, 0);
        reset_mid_cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                  flag_op_t'($urandom_range(0, 3)), 5'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0));
            if (i == 1500) reset_mid_cycle();
        end

        idle_inputs();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_file.md
# flag_file

Parametrised processor status register: the successor to the fixed five-flag register. It holds NFLAGS condition flags with per-bit masked load, set/clear/toggle operations, and a LIFO shadow stack of DEPTH entries that saves and restores the flag word across interrupts and subroutine calls. It sits between the ALU flag outputs and the control unit's branch logic.

## Interface
Parameters:
- NFLAGS, 5, flag word width; bit order {N,Z,C,B,V} for the default width, MSB first
- DEPTH, 4, shadow-stack entries (≥1)
- RESET_VAL, '0, flag word value after reset

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_en  in  1  masked load of flags_in
- load_mask  in  NFLAGS  bits to be loaded when load_en=1
- flags_in  in  NFLAGS  new flag values from the ALU
- op  in  2  flag_op_t: NOP, SET, CLR, TOG
- op_mask  in  NFLAGS  bits that op acts on
- push  in  1  save the current flag word to the stack
- pop  in  1  restore the flag word from the stack
- err_clr  in  1  clear sticky errors
- flags_out  out  NFLAGS  registered flag word
- depth  out  $clog2(DEPTH+1)  occupied stack entries
- stack_empty  out  1  depth==0
- stack_full  out  1  depth==DEPTH
- overflow_err  out  1  sticky: push while full
- underflow_err  out  1  sticky: pop while empty

## Operation
- Reset (async assert, sync-safe release): flags_out=RESET_VAL, depth=0, stack_empty=1, stack_full=0, both errors=0. Stack contents are don't-care.
- Normal next-value calculation (no effective pop), applied in order:
  - load: f = (flags & ~load_mask) | (flags_in & load_mask) if load_en.
  - op on f: SET f|=op_mask; CLR f&=~op_mask; TOG f^=op_mask; NOP unchanged.
- Push only, not full: stack[depth] ← current flags_out (pre-update value); depth+1. The normal calculation still updates the flags.
- Push only, full: push is ignored; overflow_err←1; the normal calculation still applies.
- Pop only, not empty: flags ← stack[depth-1]; depth-1. Load and op are ignored that cycle.
- Pop only, empty: pop is ignored; underflow_err←1; the normal calculation applies.
- Push and pop together, depth>0: swap. stack[depth-1] ← current flags, flags ← stack[depth-1], depth unchanged, no errors, even when full. Load and op are ignored.
- Push and pop together, depth==0: underflow_err←1; the push proceeds as a push-only; the normal calculation applies.
- err_clr clears both errors. An error event in the same cycle wins, so the error is set.
- depth saturates in the range 0..DEPTH and never wraps.

## Timing
- All state updates on the rising edge of clk. Every effect is visible on the outputs 1 cycle after the inputs are sampled.
- flags_out, depth, stack_empty, stack_full and both error flags are direct register outputs or decoded from depth. There is no combinational path from any input to any output.
- Reset is asserted asynchronously at any time, including mid push/pop. It returns every output to its reset value immediately.

## Structure
- Package ahmes_flags_pkg:
  - flag_op_t enum (NOP=0, SET=1, CLR=2, TOG=3)
  - localparams FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_B=1, FLAG_V=0
  - default NFLAGS=5
- Sub-module flag_stack:
  - LIFO of DEPTH×NFLAGS with depth counter, full/empty, and push/pop/swap
  - flag_file instantiates it and owns the flag register, the load/op logic and the error flags.

## Test plan
- Reset: drive reset_n low mid-cycle with flags=5'b10110 and depth=2 → outputs go immediately to flags_out=0, depth=0, stack_empty=1, errors=0.
- Masked load: flags=5'b00000, load_en=1, load_mask=5'b10100, flags_in=5'b11111 → 5'b10100 next cycle. In the same cycle op=TOG with op_mask=5'b00001 → 5'b10101.
- Push/pop round-trip: flags=5'b01001, push; then load 5'b11111 (full mask); then pop → flags_out=5'b01001, depth back to 0. The load in the pop cycle is ignored.
- Fill/overflow with DEPTH=4: 5 pushes → depth=4, stack_full=1, overflow_err=1, stack unchanged. The errors clear only on err_clr in a cycle with no new error.
- Underflow: pop when empty with load_en=1 and flags_in=5'b00011 (full mask) → underflow_err=1, flags=5'b00011, depth=0.
- Swap: depth=1, stack top=5'b10000, flags=5'b00001, push+pop → flags=5'b10000, top=5'b00001, depth=1, no errors.
